// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared state encodings, stage indices and helpers for the phase scheduler
//
// Purpose: single source for the scheduler's state codes, the stage bit
// positions used on stage_start/stage_done, and the default watchdog limit.
package accel_pkg;

  localparam logic [2:0] ST_IDLE       = 3'b000;
  localparam logic [2:0] ST_GET_PARAM  = 3'b001;
  localparam logic [2:0] ST_GET_DATA   = 3'b010;
  localparam logic [2:0] ST_EX         = 3'b011;
  localparam logic [2:0] ST_WRIT_PRE   = 3'b100;
  localparam logic [2:0] ST_WRITE_BACK = 3'b101;
  localparam logic [2:0] ST_DONE       = 3'b110;
  localparam logic [2:0] ST_ERROR      = 3'b111;

  localparam int STG_GET_PARAM  = 0;
  localparam int STG_GET_DATA   = 1;
  localparam int STG_EX         = 2;
  localparam int STG_WRIT_PRE   = 3;
  localparam int STG_WRITE_BACK = 4;

  localparam int TIMEOUT_DEFAULT = 1024;

  // One-hot stage bit for a stage state; all zeros for IDLE/DONE/ERROR.
  function automatic logic [4:0] stage_mask(input logic [2:0] s);
    logic [4:0] m;
    m = '0;
    case (s)
      ST_GET_PARAM:  m[STG_GET_PARAM]  = 1'b1;
      ST_GET_DATA:   m[STG_GET_DATA]   = 1'b1;
      ST_EX:         m[STG_EX]         = 1'b1;
      ST_WRIT_PRE:   m[STG_WRIT_PRE]   = 1'b1;
      ST_WRITE_BACK: m[STG_WRITE_BACK] = 1'b1;
      default:       m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// rtl/stage_watchdog.sv - per-stage cycle watchdog
//
// Purpose: counts cycles spent in the current stage; expired is high once the
// count reaches TIMEOUT-1.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - synchronous active-low reset
//   restart - clear the count (asserted on the edge that enters a new state)
//   tick    - advance the count by one
//   expired - count has reached TIMEOUT-1
module stage_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic tick,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Saturates at LAST so a stalled count can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (tick && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/phase_scheduler.sv
// rtl/phase_scheduler.sv - five-stage iterating phase scheduler with watchdog
//
// Purpose: sequences GET_PARAM -> GET_DATA -> EX -> WRIT_PRE -> WRITE_BACK for
// iter_limit iterations, with early finish, per-stage timeout and clear.
// Ports:
//   clk, rst_n   - clock and synchronous active-low reset
//   start        - begin a run (IDLE only); iter_limit latched with it
//   iter_limit   - number of full iterations
//   finish       - early termination from any stage
//   clear        - leave DONE/ERROR back to IDLE
//   stage_done   - per-stage completion, bit0 GET_PARAM .. bit4 WRITE_BACK
//   stage_start  - one-cycle launch pulse on the first cycle of each stage
//   state        - current state code
//   iter_cnt     - completed iterations
//   busy/done/error - stage state / DONE / ERROR indicators
module phase_scheduler
  import accel_pkg::*;
#(
  parameter int ITER_W  = 16,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ITER_W-1:0] iter_limit,
  input  logic              finish,
  input  logic              clear,
  input  logic [4:0]        stage_done,
  output logic [4:0]        stage_start,
  output logic [2:0]        state,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              busy,
  output logic              done,
  output logic              error
);

  logic [2:0]        state_q, state_d;
  logic [ITER_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [ITER_W-1:0] limit_q, limit_d;
  logic [4:0]        pulse_q, pulse_d;
  logic              in_stage;
  logic              cur_done;
  logic              expired;
  logic              state_change;

  assign in_stage = (stage_mask(state_q) != 5'd0);
  // Only the bit belonging to the current stage counts as completion.
  assign cur_done = |(stage_done & stage_mask(state_q));
  assign cnt_inc  = cnt_q + ITER_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          limit_d = iter_limit;
          state_d = (iter_limit == '0) ? ST_DONE : ST_GET_PARAM;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (clear) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        // Stage states: finish beats completion, completion beats timeout.
        if (finish) begin
          state_d = ST_DONE;
        end else if (cur_done) begin
          if (state_q == ST_WRITE_BACK) begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == limit_q) ? ST_DONE : ST_GET_PARAM;
          end else begin
            state_d = state_q + 3'd1;
          end
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
    endcase
  end

  assign state_change = (state_d != state_q);
  // Registered launch pulse: set only on the edge that enters a stage, so it
  // is high for exactly that stage's first cycle (WRITE_BACK -> GET_PARAM too).
  assign pulse_d = state_change ? stage_mask(state_d) : 5'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      limit_q <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      pulse_q <= pulse_d;
    end
  end

  stage_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(state_change),
    .tick   (in_stage && !cur_done),
    .expired(expired)
  );

  assign stage_start = pulse_q;
  assign state       = state_q;
  assign iter_cnt    = cnt_q;
  // Gated by rst_n so indicators drop as soon as reset is asserted.
  assign busy  = rst_n && in_stage;
  assign done  = rst_n && (state_q == ST_DONE);
  assign error = rst_n && (state_q == ST_ERROR);

endmodule

// File: tb/tb_phase_scheduler.sv
// tb/tb_phase_scheduler.sv - self-checking bench for phase_scheduler
module tb_phase_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] iter_limit;
  logic        finish;
  logic        clear;
  logic [4:0]  stage_done;
  logic [4:0]  stage_start;
  logic [2:0]  state;
  logic [15:0] iter_cnt;
  logic        busy;
  logic        done;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  int dly [32];
  int fin_k;
  int to_k;

  phase_scheduler #(
    .ITER_W (16),
    .TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .iter_limit (iter_limit),
    .finish     (finish),
    .clear      (clear),
    .stage_done (stage_done),
    .stage_start(stage_start),
    .state      (state),
    .iter_cnt   (iter_cnt),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Terminal state checks, then confirm start/finish are ignored there and
  // that clear (with a simultaneous start) returns to a quiet IDLE.
  task automatic end_check(input logic exp_err, input int exp_cnt);
    logic [2:0] es;
    es = exp_err ? 3'd7 : 3'd6;
    chk("end_state", 32'(state), 32'(es));
    chk("end_done", 32'(done), 32'(!exp_err));
    chk("end_error", 32'(error), 32'(exp_err));
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_iter_cnt", 32'(iter_cnt), 32'(exp_cnt));
    chk("end_pulse", 32'(stage_start), 32'd0);
    start = 1'b1; finish = 1'b1; stage_done = 5'($urandom);
    step();
    chk("hold_state", 32'(state), 32'(es));
    clear = 1'b1;
    step();
    chk("clear_idle", 32'(state), 32'd0);
    chk("clear_pulse", 32'(stage_start), 32'd0);
    clear = 1'b0; start = 1'b0; finish = 1'b0; stage_done = 5'd0;
    step();
    chk("idle_hold", 32'(state), 32'd0);
    chk("idle_pulse", 32'(stage_start), 32'd0);
  endtask

  // Run one job of L iterations. Stage k (k-th launch overall) is stage k%5
  // of iteration k/5; its done arrives dly[k] cycles after its launch.
  // fin_k: launch index where finish accompanies done; to_k: launch index
  // whose done is withheld (expect ERROR 8 cycles after entry).
  task automatic run(input int L);
    int n;
    int s;
    logic [4:0] bit_s;
    n = 5 * L;
    start = 1'b1; iter_limit = 16'(L);
    step();
    start = 1'b0; iter_limit = 16'($urandom);
    for (int k = 0; k < n; k++) begin
      s = k % 5;
      bit_s = 5'd1 << s;
      chk("launch_pulse", 32'(stage_start), 32'(bit_s));
      chk("launch_state", 32'(state), 32'(s + 1));
      chk("launch_busy", 32'(busy), 32'd1);
      chk("launch_iter", 32'(iter_cnt), 32'(k / 5));
      if (k == to_k) begin
        for (int c = 1; c < 8; c++) begin
          stage_done = 5'($urandom) & ~bit_s;
          step();
          chk("wd_wait_state", 32'(state), 32'(s + 1));
        end
        stage_done = 5'($urandom) & ~bit_s;
        step();
        stage_done = 5'd0;
        end_check(1'b1, k / 5);
        return;
      end
      for (int c = 0; c < dly[k]; c++) begin
        stage_done = 5'($urandom) & ~bit_s;
        step();
        chk("wait_pulse", 32'(stage_start), 32'd0);
        chk("wait_state", 32'(state), 32'(s + 1));
      end
      stage_done = bit_s | 5'($urandom);
      finish = (k == fin_k);
      step();
      stage_done = 5'd0;
      finish = 1'b0;
      if (k == fin_k) begin
        end_check(1'b0, k / 5);
        return;
      end
    end
    end_check(1'b0, L);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; iter_limit = '0; finish = 1'b0;
    clear = 1'b0; stage_done = 5'd0;
    step();
    step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pulse", 32'(stage_start), 32'd0);
    chk("rst_iter", 32'(iter_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst_n = 1'b1;
    clear = 1'b1; finish = 1'b1;
    step();
    chk("post_rst_pulse", 32'(stage_start), 32'd0);
    chk("post_rst_state", 32'(state), 32'd0);
    clear = 1'b0; finish = 1'b0;

    // Two iterations, every done 3 cycles after launch.
    for (int k = 0; k < 32; k++) dly[k] = 3;
    fin_k = -1; to_k = -1;
    run(2);

    // Zero iterations: straight to DONE, no launches.
    start = 1'b1; iter_limit = 16'd0;
    step();
    start = 1'b0;
    end_check(1'b0, 0);

    // Finish together with EX done in the second iteration.
    for (int k = 0; k < 32; k++) dly[k] = 1;
    fin_k = 7; to_k = -1;
    run(3);

    // GET_DATA done withheld: watchdog error.
    for (int k = 0; k < 32; k++) dly[k] = 0;
    fin_k = -1; to_k = 1;
    run(1);

    // Done at the last cycle before expiry still wins.
    for (int k = 0; k < 32; k++) dly[k] = 7;
    fin_k = -1; to_k = -1;
    run(1);

    // Wrong-stage done ignored, then reset mid WRIT_PRE.
    start = 1'b1; iter_limit = 16'd1;
    step();
    start = 1'b0;
    chk("d_gp_state", 32'(state), 32'd1);
    stage_done = 5'b00010;
    step();
    chk("d_stray_state", 32'(state), 32'd1);
    chk("d_stray_pulse", 32'(stage_start), 32'd0);
    step();
    chk("d_stray_state2", 32'(state), 32'd1);
    stage_done = 5'b00001;
    step();
    chk("d_gd_state", 32'(state), 32'd2);
    stage_done = 5'b00010;
    step();
    stage_done = 5'b00100;
    step();
    chk("d_wp_state", 32'(state), 32'd4);
    chk("d_wp_pulse", 32'(stage_start), 32'b01000);
    stage_done = 5'd0;
    rst_n = 1'b0;
    #1;
    chk("d_rst_busy", 32'(busy), 32'd0);
    chk("d_rst_done", 32'(done), 32'd0);
    chk("d_rst_error", 32'(error), 32'd0);
    step();
    chk("d_rst_state", 32'(state), 32'd0);
    chk("d_rst_pulse", 32'(stage_start), 32'd0);
    chk("d_rst_iter", 32'(iter_cnt), 32'd0);
    rst_n = 1'b1;
    stage_done = 5'b01000;
    step();
    chk("d_after_state", 32'(state), 32'd0);
    chk("d_after_pulse", 32'(stage_start), 32'd0);
    stage_done = 5'd0;

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      int L;
      int sel;
      L = $urandom_range(1, 3);
      for (int k = 0; k < 32; k++) dly[k] = $urandom_range(0, 7);
      sel = $urandom_range(0, 2);
      fin_k = -1; to_k = -1;
      if (sel == 1) fin_k = $urandom_range(0, 5 * L - 1);
      else if (sel == 2) to_k = $urandom_range(0, 5 * L - 1);
      run(L);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/phase_scheduler.md
PHASE_SCHEDULER -- requirements
Module: phase_scheduler

Interface
REQ-001 The block SHALL have parameter ITER_W, default 16, meaning iteration counter and limit width.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of cycles allowed per stage before an error is raised.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: begin a run, sampled in IDLE only.
REQ-006 The block SHALL have port iter_limit, input, ITER_W bits: number of full iterations, latched on accepted start.
REQ-007 The block SHALL have port finish, input, 1 bit: external early termination.
REQ-008 The block SHALL have port clear, input, 1 bit: leave DONE or ERROR and return to IDLE.
REQ-009 The block SHALL have port stage_done, input, 5 bits: per-stage completion, bit0 GET_PARAM … bit4 WRITE_BACK.
REQ-010 The block SHALL have port stage_start, output, 5 bits: one-hot single-cycle stage launch pulse, same bit order as stage_done.
REQ-011 The block SHALL have port state, output, 3 bits: current state encoding.
REQ-012 The block SHALL have port iter_cnt, output, ITER_W bits: number of completed iterations.
REQ-013 The block SHALL have port busy, output, 1 bit: high in stage states 001–101.
REQ-014 The block SHALL have port done, output, 1 bit: high when state == DONE.
REQ-015 The block SHALL have port error, output, 1 bit: high when state == ERROR.

Function
REQ-016 State encodings SHALL be: IDLE 000, GET_PARAM 001, GET_DATA 010, EX 011, WRIT_PRE 100, WRITE_BACK 101, DONE 110, ERROR 111.
REQ-017 In IDLE, start=1 with iter_limit≠0 SHALL latch iter_limit, clear iter_cnt to 0, and enter GET_PARAM next cycle.
REQ-018 In IDLE, start=1 with iter_limit=0 SHALL enter DONE next cycle with iter_cnt=0.
REQ-019 stage_start[i] SHALL be 1 for exactly the first cycle spent in stage i, and 0 at all other times.
REQ-020 In stage i, stage_done[i]=1, sampled on any cycle including the entry cycle, SHALL advance the block to the next stage on the following clock edge, in the order GET_PARAM→GET_DATA→EX→WRIT_PRE→WRITE_BACK.
REQ-021 stage_done bits for stages other than the current stage SHALL be ignored.
REQ-022 On stage_done[4] in WRITE_BACK, iter_cnt SHALL increment by 1.
REQ-023 On stage_done[4] in WRITE_BACK, the next state SHALL be DONE if iter_cnt+1 == latched limit, else GET_PARAM.
REQ-024 The iter_cnt increment SHALL never wrap, because the limit is reached first.
REQ-025 finish=1 in any stage state SHALL force DONE next cycle, with priority over stage_done and the timeout, and iter_cnt SHALL be left unchanged.
REQ-026 finish SHALL be ignored in IDLE, DONE and ERROR.
REQ-027 A per-stage watchdog SHALL clear on every stage entry and increment each cycle without a matching stage_done.
REQ-028 When the watchdog reaches TIMEOUT-1 without done or finish, the block SHALL enter ERROR next cycle.
REQ-029 DONE and ERROR SHALL hold until clear=1, then the block SHALL enter IDLE; start in the same cycle SHALL be ignored.
REQ-030 clear SHALL be ignored in IDLE and in stage states.
REQ-031 Changes to iter_limit after start SHALL have no effect on the current run.

Reset
REQ-032 rst_n=0 at a clock edge SHALL set state=IDLE, stage_start=0, iter_cnt=0, latched limit=0 and watchdog=0, regardless of the current state, including mid-stage.
REQ-033 While rst_n=0, busy, done and error SHALL be 0.
REQ-034 No stage_start pulse SHALL be emitted in the cycle after reset release unless start was accepted.

Structure
REQ-035 A shared package accel_pkg SHALL hold the state encodings, the stage index constants 0–4, and the TIMEOUT default.
REQ-036 The watchdog SHALL be a sub-module stage_watchdog with inputs clk, rst_n, restart and tick, and output expired.

Verification
REQ-037 The bench SHALL cover: iter_limit=2, each stage_done asserted 3 cycles after its stage_start -> 10 stage_start pulses in order, then iter_cnt=2 and done=1.
REQ-038 The bench SHALL cover: iter_limit=0 with start -> DONE after 1 cycle, no stage_start pulses.
REQ-039 The bench SHALL cover: finish asserted together with stage_done[2] in EX during iteration 1 -> DONE, iter_cnt=1.
REQ-040 The bench SHALL cover: TIMEOUT=8, stage_done withheld in GET_DATA -> ERROR 8 cycles after entry; then clear -> IDLE.
REQ-041 The bench SHALL cover: rst_n low in WRIT_PRE -> IDLE and all outputs 0 next cycle; stray stage_done[3] afterwards is ignored.
REQ-042 The bench SHALL cover: stage_done[1] asserted while in GET_PARAM -> no state change.
